rescale_ctrl: RTL and testbench
===============================

Name: rescale_ctrl

Overview:
- Sequencing and flow-control wrapper around the fixed-latency `rescale` datapath, which has no valid, stall or reset of its own.
- Adds a valid/ready stream interface on both sides and tracks in-flight samples with a valid delay line matched to the rescale latency.
- Absorbs results in an output FIFO so downstream backpressure never drops data.
- Owns the rescale `shift`/`head` configuration and applies changes only when the rescale pipeline is empty.

Parameters:
- NUM_WIDTH, 33, width of the input MAC/ADD number.
- IMG_WIDTH, 16, width of the rescaled image sample.
- LATENCY, 4, clock cycles from rescale `up_data` sample to `dn_data` valid. Must match the instantiated rescale.
- FIFO_DEPTH, 8, output FIFO entries. Power of two, at least LATENCY+1.
- FIFO_AWIDTH, $clog2(FIFO_DEPTH), derived; do not override.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cfg_shift  input  8  requested rescale shift
- cfg_head  input  8  requested rescale head (saturation bit index)
- cfg_valid  input  1  config request. Held high until cfg_ready.
- cfg_ready  output  1  one-cycle pulse when the config is applied
- up_data  input  NUM_WIDTH  input sample
- up_valid  input  1  input sample valid
- up_ready  output  1  controller accepts up_data this cycle
- dn_data  output  IMG_WIDTH  output sample (FIFO head)
- dn_valid  output  1  FIFO non-empty
- dn_ready  input  1  downstream accepts dn_data
- rs_shift  output  8  to rescale shift, registered
- rs_head  output  8  to rescale head, registered
- rs_up_data  output  NUM_WIDTH  to rescale up_data
- rs_dn_data  input  IMG_WIDTH  from rescale dn_data

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Reset values:
  - state=RUN
  - rs_shift=0, rs_head=IMG_WIDTH-1
  - valid pipe all zero, occupancy=0, FIFO empty
  - cfg_ready=0, dn_valid=0, up_ready follows its rule (high after reset if cfg_valid=0)
- Reset mid-operation discards all in-flight and buffered samples. Rescale pipeline contents are ignored because the valid pipe is cleared.
- rs_up_data = up_data, combinational passthrough.
- issue = up_valid & up_ready.
- up_ready = (state==RUN) & ~cfg_valid & (occupancy < FIFO_DEPTH).
- occupancy counter, width FIFO_AWIDTH+1:
  - +1 on issue, −1 on a dn handshake (dn_valid & dn_ready); both in one cycle leaves it unchanged.
  - Counts in-flight plus buffered samples, so the FIFO can never overflow.
- Valid pipe vp[LATENCY-1:0]:
  - vp[0] <= issue, vp[i] <= vp[i-1].
  - When vp[LATENCY-1]=1, rs_dn_data is written to the FIFO at that edge.
  - Issue in cycle t gives a FIFO write at the end of cycle t+LATENCY and dn_valid in cycle t+LATENCY+1. Minimum latency is 5 cycles at default.
- FIFO:
  - Simultaneous push and pop is allowed, including when the FIFO is full and a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - dn_data is valid whenever dn_valid=1 and stays stable while dn_valid & ~dn_ready.
- Throughput: 1 sample/cycle sustained when dn_ready=1 continuously.
- State machine:
  - RUN: on cfg_valid go to DRAIN. cfg_valid blocks new issue in the same cycle.
  - DRAIN: up_ready=0. When vp == 0, go to APPLY. FIFO contents need not drain.
  - APPLY: rs_shift<=cfg_shift, rs_head<=cfg_head, cfg_ready=1 for this cycle only, next state RUN.
- Samples issued before a config change are processed entirely with the old config. Samples issued after are processed entirely with the new config.
- cfg_valid with no traffic in flight: RUN→DRAIN→APPLY. cfg_ready is asserted 2 cycles after cfg_valid rises.
- cfg_valid dropped before cfg_ready is a protocol violation. Behaviour is undefined and does not need to be checked.

Test Plan:
- Reset then stream 20 samples of 0x00000100+k with shift=4, head=15, dn_ready=1 → dn_data = 0x0010+(k>>4) in order, first dn_valid 5 cycles after the first issue, no gaps.
- Default config, up_data=0x000010000 (> IMG_MAX) then 0x1FFFF0000 (negative, large) → dn_data=0x7FFF then 0x8000.
- dn_ready=0 while up_valid=1 → exactly FIFO_DEPTH (8) samples accepted, then up_ready=0. Release dn_ready → all 8 emerge in order, none lost or duplicated.
- Mid-stream cfg_valid with shift changing 0→8 → up_ready drops, cfg_ready pulses once after the last in-flight sample is written, and every output reflects exactly old or new shift by issue order.
- Simultaneous push/pop with FIFO full and dn_ready toggling every cycle → occupancy never exceeds 8, outputs ordered.
- rst asserted for 1 cycle with 3 samples in flight and 4 buffered → dn_valid=0 next cycle, rs_shift=0, rs_head=15, and no stale samples appear afterwards.

Source files
------------

// File: rtl/rescale_ctrl.sv
// Flow-control wrapper for the fixed-latency rescale datapath: valid pipe,
// output FIFO with occupancy-based backpressure and drained config updates.
module rescale_ctrl #(
   parameter int NUM_WIDTH   = 33,
   parameter int IMG_WIDTH   = 16,
   parameter int LATENCY     = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int FIFO_AWIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           cfg_shift,
   input  logic [7:0]           cfg_head,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [NUM_WIDTH-1:0] up_data,
   input  logic                 up_valid,
   output logic                 up_ready,
   output logic [IMG_WIDTH-1:0] dn_data,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic [7:0]           rs_shift,
   output logic [7:0]           rs_head,
   output logic [NUM_WIDTH-1:0] rs_up_data,
   input  logic [IMG_WIDTH-1:0] rs_dn_data
);

   typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

   localparam logic [FIFO_AWIDTH:0] OCC_MAX = (FIFO_AWIDTH+1)'(FIFO_DEPTH);

   state_t                 state;
   state_t                 state_nxt;
   logic [LATENCY-1:0]     vp;
   logic [FIFO_AWIDTH:0]   occ;
   logic [FIFO_AWIDTH:0]   wr_ptr;
   logic [FIFO_AWIDTH:0]   rd_ptr;
   logic [IMG_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic                   issue;
   logic                   push;
   logic                   pop;

   assign rs_up_data = up_data;
   assign issue      = up_valid & up_ready;
   assign push       = vp[LATENCY-1];
   assign pop        = dn_valid & dn_ready;
   assign dn_valid   = (wr_ptr != rd_ptr);
   assign dn_data    = mem[rd_ptr[FIFO_AWIDTH-1:0]];

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:     if (cfg_valid) state_nxt = DRAIN;
         DRAIN:   if (vp == '0)  state_nxt = APPLY;
         APPLY:   state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Occupancy covers in-flight plus buffered, so accepting is always safe
   always_comb begin
      up_ready  = 1'b0;
      cfg_ready = 1'b0;
      unique case (state)
         RUN:     up_ready  = ~cfg_valid & (occ < OCC_MAX);
         APPLY:   cfg_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rs_shift <= '0;
         rs_head  <= 8'(IMG_WIDTH-1);
      end else if (state == APPLY) begin
         rs_shift <= cfg_shift;
         rs_head  <= cfg_head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vp <= '0;
      end else begin
         vp[0] <= issue;
         for (int i = 1; i < LATENCY; i++)
            vp[i] <= vp[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ <= '0;
      end else begin
         case ({issue, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: ;
         endcase
      end
   end

   // Extra pointer bit distinguishes full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_AWIDTH-1:0]] <= rs_dn_data;
   end

endmodule

// File: tb/tb_rescale_ctrl.sv
// Scoreboard bench for rescale_ctrl with a behavioural 4-stage rescale
// datapath stub attached to the rs_* ports.
module tb_rescale_ctrl;

   localparam int LAT = 4;

   logic        clk;
   logic        rst;
   logic [7:0]  cfg_shift;
   logic [7:0]  cfg_head;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [32:0] up_data;
   logic        up_valid;
   logic        up_ready;
   logic [15:0] dn_data;
   logic        dn_valid;
   logic        dn_ready;
   logic [7:0]  rs_shift;
   logic [7:0]  rs_head;
   logic [32:0] rs_up_data;
   logic [15:0] rs_dn_data;

   rescale_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_shift  (cfg_shift),
      .cfg_head   (cfg_head),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .dn_data    (dn_data),
      .dn_valid   (dn_valid),
      .dn_ready   (dn_ready),
      .rs_shift   (rs_shift),
      .rs_head    (rs_head),
      .rs_up_data (rs_up_data),
      .rs_dn_data (rs_dn_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rescale_f(input logic [32:0] d,
                                             input logic [7:0] sh,
                                             input logic [7:0] hd);
      longint v;
      longint mx;
      longint mn;
      v  = longint'($signed(d));
      v  = v >>> sh;
      mx = (longint'(1) <<< hd) - 1;
      mn = -(longint'(1) <<< hd);
      if (v > mx) v = mx;
      if (v < mn) v = mn;
      return v[15:0];
   endfunction

   logic [15:0] rsp [LAT];
   always @(posedge clk) begin
      rsp[0] <= rescale_f(rs_up_data, rs_shift, rs_head);
      for (int i = 1; i < LAT; i++) rsp[i] <= rsp[i-1];
   end
   assign rs_dn_data = rsp[LAT-1];

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [15:0] exp_q [$];
   bit          cfg_phase = 0;
   int          last_issue = 0;
   int          first_dn = -1;
   int          last_dn = -1;
   int          dn_cnt = 0;
   int          cfg_pulses = 0;
   int          bad_rdy = 0;
   int          occ_m = 0;
   int          max_occ = 0;
   bit          track_occ = 0;
   bit          hold_v = 0;
   logic [15:0] hold_d;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst) occ_m <= 0;
      else occ_m <= occ_m + int'(up_valid && up_ready)
                          - int'(dn_valid && dn_ready);
   end

   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst && dn_valid && dn_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_dn got=%h want=none", dn_data);
         end else begin
            e = exp_q.pop_front();
            if (dn_data !== e) begin
               n_err++;
               $display("FAIL dn_data got=%h want=%h", dn_data, e);
            end
         end
         if (first_dn < 0) first_dn = cyc;
         last_dn = cyc;
         dn_cnt++;
      end
      if (!rst && hold_v && dn_valid) begin
         n_vec++;
         if (dn_data !== hold_d) begin
            n_err++;
            $display("FAIL dn_stable got=%h want=%h", dn_data, hold_d);
         end
      end
      hold_v = !rst && dn_valid && !dn_ready;
      hold_d = dn_data;
      if (cfg_ready) cfg_pulses++;
      if (cfg_valid && up_ready) bad_rdy++;
      if (track_occ && occ_m > max_occ) max_occ = occ_m;
   end

   task automatic chk(input string nm, input longint got, input longint want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic send(input logic [32:0] d, input logic [15:0] e0,
                       input logic [15:0] e1);
      bit ok;
      ok       = 0;
      up_data  = d;
      up_valid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (up_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout got=up_ready_low want=accept");
      end else begin
         exp_q.push_back(cfg_phase ? e1 : e0);
         last_issue = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] sh, input logic [7:0] hd,
                         output int lat);
      lat       = -1;
      cfg_shift = sh;
      cfg_head  = hd;
      cfg_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (cfg_ready) begin
            lat       = n;
            cfg_phase = 1;
            break;
         end
      end
      if (lat < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL cfg_timeout got=no_cfg_ready want=pulse");
      end
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      bit ok;
      ok       = 0;
      dn_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !dn_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_drain got=%0d_pending want=0", nm, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int t0;
      int acc;
      int p0;
      int c0;
      rst       = 1'b1;
      cfg_shift = '0;
      cfg_head  = '0;
      cfg_valid = 1'b0;
      up_data   = '0;
      up_valid  = 1'b0;
      dn_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_up_ready", up_ready, 1);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_rs_shift", rs_shift, 0);
      chk("rst_rs_head", rs_head, 15);
      @(posedge clk);
      #1;

      // default config saturation both ways
      send(33'h0_0001_0000, 16'h7FFF, 16'h7FFF);
      send(33'h1_FFFF_0000, 16'h8000, 16'h8000);
      up_valid = 1'b0;
      drain("dflt");

      // mid-stream config change shift 0 -> 8
      cfg_phase = 0;
      p0 = cfg_pulses;
      fork
         begin
            for (int k = 0; k < 12; k++)
               send(33'h100 * 33'(k + 1), 16'h100 * 16'(k + 1), 16'(k + 1));
            up_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            do_cfg(8'd8, 8'd15, lat);
         end
      join
      drain("midcfg");
      chk("cfg_midstream_lat", lat, 5);
      chk("cfg_pulse_once", cfg_pulses - p0, 1);
      chk("cfg_rs_shift8", rs_shift, 8);

      // idle config: cfg_ready two cycles after cfg_valid
      cfg_phase = 0;
      do_cfg(8'd4, 8'd15, lat);
      chk("cfg_idle_lat", lat, 2);
      chk("cfg_rs_shift4", rs_shift, 4);
      chk("cfg_rs_head15", rs_head, 15);

      // sustained stream
      first_dn = -1;
      t0 = 0;
      for (int k = 0; k < 20; k++) begin
         send(33'h100 + 33'(k), 16'h10 + 16'(k >> 4), 16'h10 + 16'(k >> 4));
         if (k == 0) t0 = last_issue;
      end
      up_valid = 1'b0;
      drain("stream");
      chk("first_dn_latency", first_dn - t0, 5);
      chk("stream_span", last_dn - first_dn, 19);

      // backpressure: exactly FIFO_DEPTH accepted
      dn_ready = 1'b0;
      up_valid = 1'b1;
      acc = 0;
      for (int k = 0; k < 16; k++) begin
         up_data = 33'h1000 + 33'(acc * 16);
         @(negedge clk);
         if (up_ready) begin
            exp_q.push_back(16'h100 + 16'(acc));
            acc++;
         end
         @(posedge clk);
         #1;
      end
      chk("bp_accepted", acc, 8);
      chk("bp_up_ready_low", up_ready, 0);
      up_valid = 1'b0;
      drain("bp");

      // full FIFO with dn_ready toggling
      track_occ = 1;
      max_occ = 0;
      dn_ready = 1'b0;
      up_valid = 1'b1;
      acc = 0;
      for (int k = 0; k < 40; k++) begin
         up_data = 33'h3000 + 33'(acc * 16);
         @(negedge clk);
         if (up_ready) begin
            exp_q.push_back(16'h300 + 16'(acc));
            acc++;
         end
         @(posedge clk);
         #1;
         dn_ready = ~dn_ready;
      end
      up_valid = 1'b0;
      drain("toggle");
      track_occ = 0;
      chk("toggle_max_occ", max_occ, 8);

      // reset with 3 in flight and 4 buffered
      dn_ready = 1'b0;
      for (int k = 0; k < 7; k++)
         send(33'h2000 + 33'(k * 16), 16'h200 + 16'(k), 16'h200 + 16'(k));
      up_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_dn_valid", dn_valid, 1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_dn_valid", dn_valid, 0);
      chk("post_rst_rs_shift", rs_shift, 0);
      chk("post_rst_rs_head", rs_head, 15);
      chk("post_rst_up_ready", up_ready, 1);
      c0 = dn_cnt;
      dn_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("no_stale_out", dn_cnt - c0, 0);
      @(posedge clk);
      #1;
      send(33'h0_0000_1234, 16'h1234, 16'h1234);
      send(33'h1_FFFF_FFF0, 16'hFFF0, 16'hFFF0);
      up_valid = 1'b0;
      drain("post_rst");

      chk("up_ready_blocked_by_cfg", bad_rdy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
